// File: rtl/divider_top_if.sv
`default_nettype none
// ============================================================================
//  Module      : divider_top_if
//  Description : Request/result bundle between the instruction decoder and
//                the sequential RV32M divider.
//                master : decoder side (drives operands and the request)
//                slave  : divider side (returns result, done and busy)
//  Revision    : 1.0 - initial release
// ============================================================================
interface divider_top_if #(
    parameter int XLEN = 32
);
    logic            div_en_i;
    logic [XLEN-1:0] op_A_i;
    logic [XLEN-1:0] op_B_i;
    logic            signed_A_i;
    logic            signed_B_i;
    logic            rem_i;
    logic [XLEN-1:0] result_o;
    logic            done_o;
    logic            busy_o;

    modport master (
        output div_en_i, op_A_i, op_B_i, signed_A_i, signed_B_i, rem_i,
        input  result_o, done_o, busy_o
    );

    modport slave (
        input  div_en_i, op_A_i, op_B_i, signed_A_i, signed_B_i, rem_i,
        output result_o, done_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/divider_top.sv
`default_nettype none
// ============================================================================
//  Module      : divider_top
//  Description : Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU.
//                Magnitudes are divided unsigned, one quotient bit per cycle,
//                and signs are applied in a final fix-up cycle. Divide by
//                zero and signed overflow skip the iteration entirely.
//  Ports       : clk_i  - clock, rising edge
//                rst_i  - synchronous active-high reset
//                bus    - divider_top_if.slave (request, operands, flags,
//                         result_o / done_o / busy_o)
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_top #(
    parameter int XLEN = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    divider_top_if.slave  bus
);
    localparam int                c_CNT_W    = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]   c_MIN      = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]    r_rem;      // partial remainder
    logic [XLEN-1:0]    r_quo;      // dividend bits out, quotient bits in
    logic [XLEN-1:0]    r_abs_b;
    logic [XLEN-1:0]    r_raw_a;    // remainder of a divide by zero
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_sel_rem;
    logic               r_div_zero;
    logic               r_ovf;
    logic [XLEN-1:0]    r_result;

    logic               w_neg_a;
    logic               w_neg_b;
    logic [XLEN-1:0]    w_abs_a;
    logic [XLEN-1:0]    w_abs_b;
    logic               w_div_zero;
    logic               w_ovf;
    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_diff;
    logic               w_q_bit;
    logic [XLEN-1:0]    w_fix_result;

    // Operand decode, evaluated only when a request is accepted in IDLE
    assign w_neg_a    = bus.signed_A_i & bus.op_A_i[XLEN-1];
    assign w_neg_b    = bus.signed_B_i & bus.op_B_i[XLEN-1];
    assign w_abs_a    = w_neg_a ? -bus.op_A_i : bus.op_A_i;
    assign w_abs_b    = w_neg_b ? -bus.op_B_i : bus.op_B_i;
    assign w_div_zero = (bus.op_B_i == '0);
    assign w_ovf      = bus.signed_A_i & bus.signed_B_i &
                        (bus.op_A_i == c_MIN) & (bus.op_B_i == '1);

    // One restoring step: the extra top bit of the trial subtraction is the
    // borrow, so a clear MSB means the shifted remainder was >= |B|.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_abs_b};
    assign w_q_bit = ~w_diff[XLEN];

    always_comb begin
        w_fix_result = '0;
        if (r_div_zero) begin
            w_fix_result = r_sel_rem ? r_raw_a : '1;
        end else if (r_ovf) begin
            w_fix_result = r_sel_rem ? '0 : c_MIN;
        end else if (r_sel_rem) begin
            w_fix_result = r_neg_r ? -r_rem : r_rem;
        end else begin
            w_fix_result = r_neg_q ? -r_quo : r_quo;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.div_en_i) begin
                    w_next_state = (w_div_zero | w_ovf) ? c_FIX : c_CALC;
                end
            end
            c_CALC: begin
                if (r_cnt == '0) begin
                    w_next_state = c_FIX;
                end
            end
            c_FIX:   w_next_state = c_DONE;
            c_DONE: begin
                // Request must be released before another one is accepted
                if (!bus.div_en_i) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy_o   = (r_state == c_CALC) || (r_state == c_FIX);
        bus.done_o   = (r_state == c_DONE);
        bus.result_o = r_result;
    end

    // Datapath
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_abs_b    <= '0;
            r_raw_a    <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_sel_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_result   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.div_en_i) begin
                        r_cnt      <= c_CNT_LOAD;
                        r_rem      <= '0;
                        r_quo      <= w_abs_a;
                        r_abs_b    <= w_abs_b;
                        r_raw_a    <= bus.op_A_i;
                        r_neg_q    <= w_neg_a ^ w_neg_b;
                        r_neg_r    <= w_neg_a;
                        r_sel_rem  <= bus.rem_i;
                        r_div_zero <= w_div_zero;
                        r_ovf      <= w_ovf;
                    end
                end
                c_CALC: begin
                    r_rem <= w_q_bit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], w_q_bit};
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_FIX: begin
                    r_result <= w_fix_result;
                end
                default: begin
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_divider_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_top
//  Description : Self-checking bench for divider_top: directed vector table,
//                multi-cycle handshake/reset sequences and random operations
//                against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_top;
    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sa;
        logic        sb;
        logic        rem;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[11];

    always #5 clk_i = ~clk_i;

    divider_top_if #(.XLEN(XLEN)) bus ();

    divider_top #(.XLEN(XLEN)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RV32M semantics computed with wide signed arithmetic
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb, input logic rem);
        longint la, lb, q, r;
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sa && sb && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return rem ? 32'd0 : 32'h8000_0000;
        la = sa ? {{32{a[31]}}, a} : {32'd0, a};
        lb = sb ? {{32{b[31]}}, b} : {32'd0, b};
        q  = la / lb;
        r  = la % lb;
        return rem ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b,
                                   input logic sa, input logic sb);
        if (b == 32'd0) return 2;
        if (sa && sb && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Issue a request at a falling edge; operands are scrambled after E0
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic sa, input logic sb, input logic rem);
        @(negedge clk_i);
        bus.div_en_i   = 1'b1;
        bus.op_A_i     = a;
        bus.op_B_i     = b;
        bus.signed_A_i = sa;
        bus.signed_B_i = sb;
        bus.rem_i      = rem;
    endtask

    // Counts falling edges after the request until done_o; lat=-1 on timeout.
    // drop_at>0 releases div_en_i at that sample.
    task automatic wait_done(input string name, input int drop_at, output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk_i);
            if (i == 1) begin
                check({name, " busy"}, {31'd0, bus.busy_o}, 32'd1);
                bus.op_A_i     = $urandom;
                bus.op_B_i     = $urandom;
                bus.signed_A_i = 1'($urandom_range(0, 1));
                bus.signed_B_i = 1'($urandom_range(0, 1));
                bus.rem_i      = 1'($urandom_range(0, 1));
            end
            if (i == drop_at) bus.div_en_i = 1'b0;
            if (bus.done_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input logic rem,
                          input logic [31:0] exp, input int exp_lat);
        int          lat;
        logic [31:0] res;
        start_op(a, b, sa, sb, rem);
        wait_done(name, 0, lat);
        check({name, " latency"}, lat, exp_lat);
        res = bus.result_o;
        check({name, " result"}, res, exp);
        bus.div_en_i = 1'b0;
        @(negedge clk_i);
        check({name, " done clear"}, {31'd0, bus.done_o}, 32'd0);
        check({name, " result held"}, bus.result_o, exp);
    endtask

    initial begin
        int          lat;
        logic [31:0] a, b, exp;
        logic        sa, sb, rem;

        vecs[0]  = '{32'd100,       32'd7,         1'b0, 1'b0, 1'b0, 32'h0000_000E, 34};
        vecs[1]  = '{32'd100,       32'd7,         1'b0, 1'b0, 1'b1, 32'h0000_0002, 34};
        vecs[2]  = '{32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFD, 34};
        vecs[3]  = '{32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 34};
        vecs[4]  = '{32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFD, 34};
        vecs[5]  = '{32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 34};
        vecs[6]  = '{32'h1234_5678, 32'd0,         1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 2};
        vecs[7]  = '{32'h1234_5678, 32'd0,         1'b0, 1'b0, 1'b1, 32'h1234_5678, 2};
        vecs[8]  = '{32'hFFFF_FFFB, 32'd0,         1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 2};
        vecs[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 2};
        vecs[10] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 34};

        bus.div_en_i   = 1'b0;
        bus.op_A_i     = '0;
        bus.op_B_i     = '0;
        bus.signed_A_i = 1'b0;
        bus.signed_B_i = 1'b0;
        bus.rem_i      = 1'b0;
        rst_i          = 1'b1;
        repeat (3) @(negedge clk_i);
        check("reset result", bus.result_o, 32'd0);
        check("reset done", {31'd0, bus.done_o}, 32'd0);
        check("reset busy", {31'd0, bus.busy_o}, 32'd0);
        rst_i = 1'b0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sa,
                   vecs[i].sb, vecs[i].rem, vecs[i].exp, vecs[i].lat);
        run_op("ovf rem signed", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'd0, 2);
        run_op("ovf quo unsigned", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd0, 34);

        // Reset in the middle of the iteration discards the operation
        start_op(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk_i);
        rst_i        = 1'b1;
        bus.div_en_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midrst result", bus.result_o, 32'd0);
        check("midrst done", {31'd0, bus.done_o}, 32'd0);
        check("midrst busy", {31'd0, bus.busy_o}, 32'd0);
        run_op("after rst 9/3", 32'd9, 32'd3, 1'b0, 1'b0, 1'b0, 32'd3, 34);

        // Request held high: done stays up, no restart
        start_op(32'd50, 32'd6, 1'b0, 1'b0, 1'b0);
        wait_done("hold", 0, lat);
        check("hold latency", lat, 34);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("hold done", {31'd0, bus.done_o}, 32'd1);
            check("hold busy", {31'd0, bus.busy_o}, 32'd0);
            check("hold result", bus.result_o, 32'd8);
        end
        bus.div_en_i = 1'b0;
        @(negedge clk_i);
        check("hold release done", {31'd0, bus.done_o}, 32'd0);
        check("hold release result", bus.result_o, 32'd8);

        // Request dropped mid-iteration: single-cycle done pulse
        start_op(32'hFFFF_FF9C, 32'd9, 1'b1, 1'b1, 1'b1);
        wait_done("drop", 5, lat);
        check("drop latency", lat, 34);
        check("drop result", bus.result_o, 32'hFFFF_FFFF);
        @(negedge clk_i);
        check("drop pulse end", {31'd0, bus.done_o}, 32'd0);
        check("drop result held", bus.result_o, 32'hFFFF_FFFF);

        // Random operations against the reference model
        for (int n = 0; n < 40; n++) begin
            a   = $urandom;
            b   = $urandom;
            sa  = 1'($urandom_range(0, 1));
            sb  = ($urandom_range(0, 5) == 0) ? ~sa : sa;
            rem = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = -$urandom_range(1, 15);
                default: begin end
            endcase
            exp = ref_div(a, b, sa, sb, rem);
            run_op($sformatf("rnd%0d a=%08h b=%08h s=%0d%0d r=%0d", n, a, b, sa, sb, rem),
                   a, b, sa, sb, rem, exp, ref_lat(a, b, sa, sb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
